pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Parametrised instruction-fetch stage for the GCD CPU pipeline. It holds the program counter and an on-chip instruction memory with a load port, and presents one instruction per cycle to decode with its PC and a valid flag. Unconditional jumps are pre-decoded with zero bubbles, and execute-stage redirects (taken beq) take priority. Stall and fault handling are built in, and width, depth and reset vector are set by parameters.

## Interface
- XLEN, 32, PC / address width (≥ 16)
- IMEM_DEPTH, 128, instruction words in memory (power of two)
- RESET_PC, 0, PC value loaded on reset (word aligned)
- EARLY_JUMP, 1, 1 = pre-decode `j` in fetch; 0 = no pre-decode, jumps arrive via redirect
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC, ir, ir_pc, ir_valid
- redirect_valid  in  1  taken branch/jump from execute
- redirect_target  in  XLEN  new PC on redirect
- imem_we  in  1  instruction-memory write strobe
- imem_waddr  in  $clog2(IMEM_DEPTH)  word index to write
- imem_wdata  in  32  instruction word
- pc  out  XLEN  current fetch address
- ir  out  32  fetched instruction
- ir_pc  out  XLEN  address of the instruction in ir
- ir_valid  out  1  ir holds a real instruction
- fault  out  1  sticky fetch fault

## Operation
- Fetch word: fw = imem[pc[IDX+1:2]], combinational read, where IDX = $clog2(IMEM_DEPTH).
- Fault condition: pc[1:0] != 0 or pc[XLEN-1:2] ≥ IMEM_DEPTH.
- Next-state priority per edge, highest first:
  1. redirect_valid: pc <= redirect_target; ir_valid <= 0. Overrides stall and early jump.
  2. fault set or fault condition true: fault <= 1; ir_valid <= 0; pc holds. Fault stays set until rst.
  3. stall: all registers hold.
  4. Normal fetch: ir <= fw; ir_pc <= pc; ir_valid <= 1.
     - If EARLY_JUMP and fw[31:26] == OP_J: pc <= {pc[XLEN-1:28], fw[25:0], 2'b00}.
     - Otherwise pc <= pc + 4, wrapping modulo 2^XLEN.
- beq (OP_BEQ) is not resolved here. Execute uses ir_pc and asserts redirect_valid when taken. Instructions fetched after the beq are flushed by the redirect.
- Memory writes are synchronous on imem_we, independent of stall, fault and rst. A fetch from the address being written in the same cycle returns the old word.
- Memory contents are not cleared by rst.

## Timing
- Reset values: pc = RESET_PC, ir = 0, ir_pc = 0, ir_valid = 0, fault = 0. rst takes effect immediately, including mid-operation; pending redirects are discarded.
- First edge after rst is released: ir = imem[RESET_PC>>2], ir_valid = 1, pc = RESET_PC + 4.
- Fetch latency is 1 cycle (pc to ir).
- Jump penalty is 0 bubbles with EARLY_JUMP = 1.
- Redirect penalty is 1 bubble: ir_valid = 0 in the cycle after the redirect edge, then the target instruction is valid on the next edge.
- redirect_valid is sampled only at the edge; it is a single-cycle pulse from execute.
- When stall and redirect_valid are both high, the redirect wins. Stall does not hold off flushes.

## Structure
- Shared package fetch_pkg:
  - OP_J = 6'd2, OP_BEQ = 6'd4
  - opcode field slice constants
  - function jump_target(pc, instr)
- Sub-module imem_array (DEPTH, WIDTH = 32): async read, sync write, no reset.
- PC/next-PC logic and the fault flag live in pc_fetch_unit.

## Test plan
- Reset and linear fetch:
  - Preload words 0..3 = 0x11111111..0x44444444, release rst.
  - Expect ir 0x11111111..0x44444444 on successive edges.
  - Expect ir_pc 0, 4, 8, 12 and ir_valid = 1 from the first edge.
- Early jump:
  - Preload word 2 = j 10 (0x0800000A).
  - Expect ir_pc sequence 0, 4, 8, 40 with no ir_valid gap.
  - With EARLY_JUMP = 0, expect ir_pc sequence 0, 4, 8, 12.
- Redirect plus stall:
  - Assert stall and redirect_valid with redirect_target = 0x20 in the same cycle.
  - Expect pc = 0x20 and ir_valid = 0 for one cycle.
  - Next edge (stall low): expect ir_pc = 0x20, ir_valid = 1.
- Stall hold:
  - Assert stall for 3 cycles at pc = 0x8.
  - Expect pc, ir, ir_pc and ir_valid unchanged; fetch resumes at 0x8 afterwards.
- Fault:
  - Redirect to 0x202 (misaligned), and separately to 4*IMEM_DEPTH (out of range).
  - Expect fault = 1, ir_valid = 0, pc frozen.
  - Expect fault cleared only by rst.
- Memory write collision:
  - Write 0xDEADBEEF to the word being fetched in the same cycle.
  - Expect the old word in ir.
  - Refetch after redirect: expect 0xDEADBEEF.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: opcode constants and jump-target helper shared by the fetch stage
package fetch_pkg;
  localparam logic [5:0] OP_J = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  function automatic logic [63:0] jump_target(input logic [63:0] pc, input logic [31:0] instr);
    return (pc & ~64'h0FFF_FFFF) | (({32'b0, instr} & 64'h03FF_FFFF) << 2);
  endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction memory, async read, sync write, no reset
module imem_array #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, early-jump pre-decode, redirect/stall/fault handling
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IMEM_DEPTH = 128,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int EARLY_JUMP = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [XLEN-1:0]               pc,
  output logic [31:0]                   ir,
  output logic [XLEN-1:0]               ir_pc,
  output logic                          ir_valid,
  output logic                          fault
);
  localparam int IDX = $clog2(IMEM_DEPTH);
  logic [XLEN-1:0] r_pc, r_ir_pc, w_next;
  logic [31:0] r_ir, w_fw;
  logic r_valid, r_fault, w_fault_cond, w_jump;
  imem_array #(.DEPTH(IMEM_DEPTH), .WIDTH(32)) u_imem (
    .clk(clk),
    .we(imem_we),
    .waddr(imem_waddr),
    .wdata(imem_wdata),
    .raddr(r_pc[IDX+1:2]),
    .rdata(w_fw)
  );
  always_comb begin
    w_fault_cond = (|r_pc[1:0]) || (r_pc[XLEN-1:2] >= (XLEN-2)'(IMEM_DEPTH));
    w_jump = (EARLY_JUMP != 0) && (w_fw[OPC_HI:OPC_LO] == OP_J);
    w_next = w_jump ? XLEN'(jump_target(64'(r_pc), w_fw)) : r_pc + XLEN'(4);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_ir_pc <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= redirect_target;
      r_valid <= 1'b0;
    end else if (r_fault || w_fault_cond) begin
      r_fault <= 1'b1;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_ir <= w_fw;
      r_ir_pc <= r_pc;
      r_valid <= 1'b1;
      r_pc <= w_next;
    end
  assign pc = r_pc;
  assign ir = r_ir;
  assign ir_pc = r_ir_pc;
  assign ir_valid = r_valid;
  assign fault = r_fault;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of two fetch units (EARLY_JUMP 1 and 0)
module tb_pc_fetch_unit;
  localparam int DEPTH = 128;
  logic clk = 0, rst = 1, stall = 0, rv = 0, we = 0;
  logic [31:0] rt = 0, wd = 0;
  logic [6:0] wa = 0;
  logic [31:0] pc [2], ir [2], irpc [2];
  logic v [2], f [2];
  int tests = 0, fails = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] m_pc [2], m_ir [2], m_irpc [2];
  logic m_v [2], m_f [2];
  logic [31:0] old;

  pc_fetch_unit #(.XLEN(32), .IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .EARLY_JUMP(1)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_target(rt),
    .imem_we(we), .imem_waddr(wa), .imem_wdata(wd),
    .pc(pc[0]), .ir(ir[0]), .ir_pc(irpc[0]), .ir_valid(v[0]), .fault(f[0]));
  pc_fetch_unit #(.XLEN(32), .IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .EARLY_JUMP(0)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_target(rt),
    .imem_we(we), .imem_waddr(wa), .imem_wdata(wd),
    .pc(pc[1]), .ir(ir[1]), .ir_pc(irpc[1]), .ir_valid(v[1]), .fault(f[1]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.pc", k), pc[k], m_pc[k]);
      chk($sformatf("u%0d.ir", k), ir[k], m_ir[k]);
      chk($sformatf("u%0d.ir_pc", k), irpc[k], m_irpc[k]);
      chk($sformatf("u%0d.ir_valid", k), 32'(v[k]), 32'(m_v[k]));
      chk($sformatf("u%0d.fault", k), 32'(f[k]), 32'(m_f[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_ir[k] = 0; m_irpc[k] = 0; m_v[k] = 0; m_f[k] = 0;
    end
  endtask

  // Reference behaviour: one clock edge of the fetch stage, then the memory write
  task automatic step();
    logic [31:0] w;
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < 2; k++) begin
      if (rv) begin
        m_pc[k] = rt; m_v[k] = 0;
      end else if (m_f[k] || (m_pc[k] % 4 != 0) || (m_pc[k] / 4 >= DEPTH)) begin
        m_f[k] = 1; m_v[k] = 0;
      end else if (!stall) begin
        w = mem[m_pc[k] / 4];
        m_ir[k] = w; m_irpc[k] = m_pc[k]; m_v[k] = 1;
        if (k == 0 && (w >> 26) == 2) m_pc[k] = (m_pc[k] & 32'hF000_0000) + (w & 32'h03FF_FFFF) * 4;
        else m_pc[k] = m_pc[k] + 4;
      end
    end
    if (we) mem[wa] = wd;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    check_all();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we = 1; wa = 7'(a); wd = d;
    step();
    we = 0;
  endtask

  initial begin
    #2;
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom & 32'hF7FF_FFFF);
    for (int i = 0; i < 4; i++) wr(i, 32'h1111_1111 * (i + 1));
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lin_ir", ir[0], 32'h1111_1111 * (i + 1));
      chk("lin_ir_pc", irpc[0], 32'(4 * i));
      chk("lin_valid", 32'(v[0]), 32'd1);
    end

    do_reset();
    wr(2, 32'h0800_000A);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ej_ir_pc", irpc[0], (i == 3) ? 32'd40 : 32'(4 * i));
      chk("noej_ir_pc", irpc[1], 32'(4 * i));
      chk("ej_valid", 32'(v[0]), 32'd1);
    end

    do_reset();
    step();
    rst = 0;
    step();
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc[0], 32'h8);
      chk("stall_ir_pc", irpc[0], 32'h4);
      chk("stall_ir", ir[1], 32'h2222_2222);
    end
    stall = 0;
    step();
    chk("resume_ir_pc", irpc[1], 32'h8);
    chk("resume_pc_ej", pc[0], 32'd40);

    stall = 1; rv = 1; rt = 32'h20;
    step();
    chk("redir_pc", pc[0], 32'h20);
    chk("redir_valid", 32'(v[1]), 32'd0);
    stall = 0; rv = 0;
    step();
    chk("redir_ir_pc", irpc[0], 32'h20);
    chk("redir_valid2", 32'(v[0]), 32'd1);

    old = mem[9];
    we = 1; wa = 7'd9; wd = 32'hDEAD_BEEF;
    step();
    we = 0;
    chk("coll_old", ir[0], old);
    rv = 1; rt = 32'h24;
    step();
    rv = 0;
    step();
    chk("coll_new", ir[0], 32'hDEAD_BEEF);

    rv = 1; rt = 32'h202;
    step();
    rv = 0;
    step();
    chk("mis_fault", 32'(f[0]), 32'd1);
    step();
    step();
    chk("mis_pc", pc[1], 32'h202);
    chk("mis_valid", 32'(v[1]), 32'd0);
    rv = 1; rt = 32'h10;
    step();
    rv = 0;
    step();
    chk("fault_sticky", 32'(f[0]), 32'd1);
    do_reset();
    chk("fault_clear", 32'(f[0]), 32'd0);
    step();
    rst = 0;
    rv = 1; rt = 32'(4 * DEPTH);
    step();
    rv = 0;
    step();
    step();
    chk("oor_fault", 32'(f[1]), 32'd1);
    chk("oor_pc", pc[0], 32'(4 * DEPTH));

    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      step();
      rst = 0;
      for (int c = 0; c < 250; c++) begin
        stall = ($urandom % 4) == 0;
        rv = ($urandom % 6) == 0;
        rt = (($urandom % 20) == 0) ? ($urandom % 1024) : 32'($urandom_range(0, DEPTH - 1) * 4);
        we = ($urandom % 3) == 0;
        wa = 7'($urandom);
        wd = (($urandom % 5) == 0) ? (32'h0800_0000 | 32'($urandom_range(0, DEPTH - 1))) : ($urandom & 32'hF7FF_FFFF);
        if (c == 150) begin
          rv = 1;
          do_reset();
          step();
          rst = 0;
        end else step();
      end
      stall = 0; rv = 0; we = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
